// File: rtl/flex_counter_ud.sv
// flex_counter_ud: up/down counter over [1, rollover_val] with wrap or one-shot stop.
// Registered rollover flag, wrap pulse and sticky done flag; async active-low reset.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_up,
    input  logic                    one_shot,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    done
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  r_state, w_next_state;
    logic [NUM_CNT_BITS-1:0] r_count, w_next_count, w_term, w_step_count;
    logic                    r_flag, w_next_flag;
    logic                    r_wrap, w_next_wrap;
    logic                    r_done, w_next_done;
    logic                    w_at_end, w_step;

    always_comb begin
        w_term       = count_up ? rollover_val : ONE;
        w_at_end     = count_up ? (r_count >= rollover_val) : (r_count <= ONE);
        w_step       = count_enable && (rollover_val != '0) && (r_state != DONE);
        // Leaving IDLE and wrapping both land on the start value for the direction
        w_step_count = (r_state == IDLE || w_at_end) ? (count_up ? ONE : rollover_val)
                                                     : (count_up ? r_count + ONE : r_count - ONE);
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_flag  = r_flag;
        w_next_done  = r_done;
        w_next_wrap  = 1'b0;
        if (clear) begin
            w_next_state = IDLE;
            w_next_count = '0;
            w_next_flag  = 1'b0;
            w_next_done  = 1'b0;
        end else if (load) begin
            w_next_state = RUN;
            w_next_count = load_val;
            w_next_flag  = (rollover_val != '0) && (load_val == w_term);
            w_next_done  = 1'b0;
        end else if (w_step) begin
            if (r_state == RUN && w_at_end && one_shot) begin
                w_next_state = DONE;
                w_next_done  = 1'b1;
            end else begin
                w_next_state = RUN;
                w_next_count = w_step_count;
                w_next_wrap  = (r_state == RUN) && w_at_end;
            end
            w_next_flag = (w_next_count == w_term);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_flag  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_flag  <= w_next_flag;
            r_wrap  <= w_next_wrap;
            r_done  <= w_next_done;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign wrap_pulse    = r_wrap;
    assign done          = r_done;
endmodule

// File: doc/flex_counter_ud.md
FLEX_COUNTER_UD -- requirements
Module: flex_counter_ud

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4, counter width in bits (legal range 2..32).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  active-high synchronous clear to 0.
REQ-005 load  input  1  active-high synchronous load of load_val.
REQ-006 load_val  input  NUM_CNT_BITS  value captured on load.
REQ-007 count_enable  input  1  active-high step enable.
REQ-008 count_up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 one_shot  input  1  mode: 0 = wrap continuously, 1 = stop at terminal value.
REQ-010 rollover_val  input  NUM_CNT_BITS  upper bound of the count range [1, rollover_val].
REQ-011 count_out  output  NUM_CNT_BITS  registered current count.
REQ-012 rollover_flag  output  1  registered; high while count_out equals the terminal value for the current direction.
REQ-013 wrap_pulse  output  1  registered; one-cycle pulse after each wrap.
REQ-014 done  output  1  registered; sticky one-shot completion flag.

Function
REQ-015 Terminal value SHALL be rollover_val when count_up=1 and 1 when count_up=0.
REQ-016 Per-cycle priority SHALL be clear > load > count_enable > hold.
REQ-017 clear SHALL set count_out=0, rollover_flag=0, wrap_pulse=0, done=0, state IDLE next cycle.
REQ-018 load SHALL set count_out=load_val, clear done and wrap_pulse, state RUN, regardless of one_shot.
REQ-019 FSM states SHALL be IDLE (count 0, no step taken), RUN, DONE; DONE reachable only with one_shot=1.
REQ-020 IDLE -> RUN on first enabled step; step from 0 SHALL give 1 when counting up and rollover_val when counting down; no wrap_pulse.
REQ-021 RUN, count_up=1: count_out < rollover_val -> count_out+1; count_out >= rollover_val -> wrap to 1.
REQ-022 RUN, count_up=0: count_out > 1 -> count_out-1; count_out <= 1 -> wrap to rollover_val.
REQ-023 A wrap with one_shot=0 SHALL assert wrap_pulse for exactly the following cycle.
REQ-024 Enabled step at terminal value with one_shot=1 SHALL hold count_out, set done=1, enter DONE; no wrap_pulse.
REQ-025 In DONE, count_enable SHALL be ignored; only clear, load or reset leave DONE.
REQ-026 rollover_flag SHALL be registered, computed from next count and current count_up, so it is valid in the same cycle count_out reaches terminal value (one-cycle latency from enable, matching count_out).
REQ-027 Direction change mid-count SHALL take effect on the next enabled step with no extra cycle; rollover_flag re-evaluated on that step.
REQ-028 rollover_val=0 SHALL hold count_out at its current value on enabled steps; rollover_flag, wrap_pulse, done stay 0.
REQ-029 rollover_val lowered below count_out while counting up SHALL cause a wrap to 1 on the next enabled step (>= compare, REQ-021).
REQ-030 Arithmetic SHALL be NUM_CNT_BITS wide unsigned; no intermediate overflow beyond rollover_val=2^N-1 (wrap to 1, never to 0).
REQ-031 count_enable low SHALL hold all registers except wrap_pulse, which clears.

Reset
REQ-032 n_rst=0 SHALL immediately force count_out=0, rollover_flag=0, wrap_pulse=0, done=0, state IDLE, independent of clk.
REQ-033 Reset asserted mid-count or in DONE SHALL discard all progress; first enabled step after release follows REQ-020.

Verification
REQ-034 N=4, rollover_val=5, up, one_shot=0, enable 12 cycles -> count_out 1,2,3,4,5,1,2,3,4,5,1,2; rollover_flag high with each 5; wrap_pulse high the cycle after each wrap (count_out=1).
REQ-035 Down, rollover_val=3, from reset, enable 7 cycles -> 3,2,1,3,2,1,3; rollover_flag high with each 1; wrap_pulse after each 1->3.
REQ-036 one_shot=1, up, rollover_val=4, enable 8 cycles -> 1,2,3,4,4,4,4,4; done=1 from the cycle after first step at 4; load with load_val=2 -> count_out=2, done=0.
REQ-037 clear, load and count_enable asserted together at count 3 -> count_out=0, all flags 0; load+enable only -> count_out=load_val, no step.
REQ-038 N=4, rollover_val=15, up at count 14, enable 2 cycles -> 15 then 1 (never 0); rollover_val changed 15->6 at count 9 -> next step 1.
REQ-039 n_rst pulsed low asynchronously between clock edges at count 7 -> outputs 0 before next edge; release, enable up -> 1.
